// File: rtl/fpu_addsub_issue_if.sv
// Operand-in / result-out handshake bundle for the add/sub issue controller.
// The master drives operands and out_ready; the slave returns in_ready and FIFO results.
interface fpu_addsub_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_r
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_r
  );
endinterface

// File: rtl/fpu_addsub_issue.sv
// Issue/collect controller for a fixed-latency, non-stallable add/sub pipeline.
// Credits (FIFO occupancy plus in-flight ops) gate admission so no result is ever dropped.
module fpu_addsub_issue #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          arst_n,
  fpu_addsub_issue_if.slave             bus,
  output logic [WIDTH-1:0]              pipe_a,
  output logic [WIDTH-1:0]              pipe_b,
  output logic                          pipe_op,
  input  logic [WIDTH-1:0]              pipe_r,
  output logic [$clog2(LATENCY+2)-1:0]  inflight,
  output logic                          ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 2);

  logic [LATENCY:0] vld_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    fifo_count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [CW:0]      credit_s;
  logic             accept_s;
  logic             capture_s;
  logic             pop_s;
  logic             push_s;
  logic             full_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Handshake and credit decode; in_ready depends on registers only.
  always_comb begin
    credit_s      = {1'b0, fifo_count_r} + (CW+1)'(inflight);
    bus.in_ready  = (credit_s < (CW+1)'(DEPTH));
    bus.out_valid = (fifo_count_r != {CW{1'b0}});
    bus.out_r     = mem_r[rd_ptr_r];
    accept_s      = bus.in_valid & bus.in_ready;
    capture_s     = vld_r[LATENCY];
    pop_s         = bus.out_valid & bus.out_ready;
    full_s        = (fifo_count_r == CW'(DEPTH));
    // A full FIFO can still take a capture if the head leaves on the same edge.
    push_s        = capture_s & (~full_s | pop_s);
  end

  // Operand registers feeding the pipeline; hold when nothing is accepted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pipe_a  <= {WIDTH{1'b0}};
      pipe_b  <= {WIDTH{1'b0}};
      pipe_op <= 1'b0;
    end else if (accept_s) begin
      pipe_a  <= bus.in_a;
      pipe_b  <= bus.in_b;
      pipe_op <= bus.in_op;
    end
  end

  // In-flight tracking: valid shift register plus its running popcount.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_r    <= {(LATENCY+1){1'b0}};
      inflight <= {IW{1'b0}};
    end else begin
      vld_r <= {vld_r[LATENCY-1:0], accept_s};
      case ({accept_s, capture_s})
        2'b10:   inflight <= inflight + IW'(1'b1);
        2'b01:   inflight <= inflight - IW'(1'b1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      fifo_count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pipe_r;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1'b1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1'b1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Sticky overflow flag: a capture found no room and no simultaneous pop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_err <= 1'b0;
    end else if (capture_s && full_s && !pop_s) begin
      ovf_err <= 1'b1;
    end
  end

endmodule
